// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA debug mirror path: row/word geometry of the
// mirror RAM and the fetch sequencer state type. The geometry constants are
// also consumed by vga_ram and the text/glyph renderer.
// ----------------------------------------------------------------------------
package vga_pkg;

    localparam int VGA_NUM_ROWS = 46;
    localparam int VGA_ADDR_W   = 6;
    localparam int VGA_WORD_W   = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } seq_state_e;

endpackage

// File: rtl/vga_row_fifo.sv
// ----------------------------------------------------------------------------
// vga_row_fifo
// Small synchronous FIFO holding tagged row words between the RAM fetch and
// the renderer. Storage is plain registers; only pointers and count are reset.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push        write wdata (ignored when full unless a pop happens too)
//   pop         drop head entry (ignored when empty)
//   flush       discard all entries; wins over push/pop
//   wdata       entry to write
//   head        oldest entry (undefined contents when empty)
//   count       number of stored entries
//   full/empty  occupancy flags
// ----------------------------------------------------------------------------
module vga_row_fifo #(
    parameter int WIDTH = 134,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    // A push into a full FIFO is fine when the head leaves in the same cycle:
    // the write lands in the slot being vacated.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    assign head = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/vga_ram_sequencer.sv
// ----------------------------------------------------------------------------
// vga_ram_sequencer
// Walks the VGA debug mirror RAM rows 0..NUM_ROWS-1 once per frame, tags each
// combinational read word with its row number and hands it to the renderer
// through a small FIFO with a valid/ready handshake.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   frame_start    pulse from VGA timing; starts (or restarts) a frame fetch
//   read_address   mirror RAM read address
//   ram_out        mirror RAM read data, combinational from read_address
//   row_data       head-of-FIFO word (0 while empty)
//   row_index      row number of row_data (0 while empty)
//   row_valid      FIFO non-empty
//   row_ready      renderer accepts the head when row_valid is high
//   busy           fetch or drain in progress
//   frame_done     one-cycle pulse after the final row of a frame is popped
//   overrun_count  saturating count of frame_start pulses seen while busy
// ----------------------------------------------------------------------------
module vga_ram_sequencer
    import vga_pkg::*;
#(
    parameter int NUM_ROWS   = VGA_NUM_ROWS,
    parameter int ADDR_W     = VGA_ADDR_W,
    parameter int DATA_W     = VGA_WORD_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    output logic [ADDR_W-1:0] read_address,
    input  logic [DATA_W-1:0] ram_out,
    output logic [DATA_W-1:0] row_data,
    output logic [ADDR_W-1:0] row_index,
    output logic              row_valid,
    input  logic              row_ready,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        overrun_count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NUM_ROWS - 1);

    seq_state_e state, state_next;
    logic [ADDR_W-1:0] addr_next;
    logic              done_next;
    logic              push;
    logic              flush;
    logic              pop;

    logic [ADDR_W+DATA_W-1:0] fifo_head;
    logic [CNT_W-1:0]         fifo_count;
    logic                     fifo_full;
    logic                     fifo_empty;

    vga_row_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata ({read_address, ram_out}),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign row_valid = ~fifo_empty;
    assign pop       = row_valid & row_ready;
    assign busy      = (state != IDLE);

    // Mask the head while empty so the outputs read as zero out of reset,
    // without having to reset the FIFO storage itself.
    assign {row_index, row_data} = fifo_empty ? '0 : fifo_head;

    always_comb begin
        state_next = state;
        addr_next  = read_address;
        done_next  = 1'b0;
        push       = 1'b0;
        flush      = 1'b0;
        case (state)
            IDLE: begin
                addr_next = '0;
                if (frame_start) state_next = FETCH;
            end
            FETCH: begin
                if (frame_start) begin
                    flush     = 1'b1;
                    addr_next = '0;
                end else if (!fifo_full || pop) begin
                    push = 1'b1;
                    if (read_address == LAST_ROW) begin
                        state_next = DRAIN;
                        addr_next  = '0;
                    end else begin
                        addr_next = read_address + 1'b1;
                    end
                end
            end
            DRAIN: begin
                addr_next = '0;
                if (frame_start) begin
                    // Restart wins over completion, even on the final pop.
                    flush      = 1'b1;
                    state_next = FETCH;
                end else if (pop && fifo_count == CNT_W'(1)) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                addr_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            read_address  <= '0;
            frame_done    <= 1'b0;
            overrun_count <= 8'd0;
        end else begin
            state        <= state_next;
            read_address <= addr_next;
            frame_done   <= done_next;
            if (frame_start && busy && overrun_count != 8'hFF)
                overrun_count <= overrun_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_vga_ram_sequencer.sv
module tb_vga_ram_sequencer;

    localparam int NR = 46;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         frame_start = 1'b0;
    logic         row_ready = 1'b1;
    logic [5:0]   read_address;
    logic [127:0] ram_out;
    logic [127:0] row_data;
    logic [5:0]   row_index;
    logic         row_valid;
    logic         busy;
    logic         frame_done;
    logic [7:0]   overrun_count;

    logic         fs_s = 1'b0;
    logic [5:0]   addr_s;
    logic [127:0] ram_s;
    logic [127:0] data_s;
    logic [5:0]   index_s;
    logic         valid_s;
    logic         busy_s;
    logic         done_s;
    logic [7:0]   ovr_s;

    assign ram_out = {4{26'h0, read_address}};
    assign ram_s   = {4{26'h0, addr_s}};

    vga_ram_sequencer u_dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .read_address(read_address), .ram_out(ram_out),
        .row_data(row_data), .row_index(row_index), .row_valid(row_valid),
        .row_ready(row_ready), .busy(busy), .frame_done(frame_done),
        .overrun_count(overrun_count)
    );

    vga_ram_sequencer #(.NUM_ROWS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .frame_start(fs_s),
        .read_address(addr_s), .ram_out(ram_s),
        .row_data(data_s), .row_index(index_s), .row_valid(valid_s),
        .row_ready(1'b1), .busy(busy_s), .frame_done(done_s),
        .overrun_count(ovr_s)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;

    // Frame-level model: which row must appear next, whether a frame is
    // in flight, how many restarts have been seen, and when a done is owed.
    bit m_busy = 1'b0;
    int m_idx  = 0;
    int m_ovr  = 0;
    bit m_done = 1'b0;
    bit p_valid = 1'b0;
    bit p_pop   = 1'b0;
    bit p_fs    = 1'b0;
    int done_count = 0;
    int rise_cyc   = -1;

    function automatic logic [127:0] word_of(input int i);
        logic [5:0] a;
        a = i[5:0];
        return {4{26'h0, a}};
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chki(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int n;
        n = 0;
        while (!frame_done && n < limit) begin
            step();
            n++;
        end
        chk1(name, frame_done, 1'b1);
    endtask

    task automatic wait_addr(input string name, input int a, input int limit);
        int n;
        n = 0;
        while (int'(read_address) != a && n < limit) begin
            step();
            n++;
        end
        chki(name, int'(read_address), a);
    endtask

    task automatic compare_step();
        bit pop;
        if (!rst_n) begin
            m_busy = 1'b0; m_idx = 0; m_ovr = 0; m_done = 1'b0;
            p_valid = 1'b0; p_pop = 1'b0; p_fs = 1'b0;
        end else begin
            chk1("busy", busy, m_busy);
            chk1("frame_done", frame_done, m_done);
            chki("overrun_count", int'(overrun_count), m_ovr);
            chk1("addr_range", int'(read_address) < NR, 1'b1);
            if (!m_busy) chk1("valid_when_idle", row_valid, 1'b0);
            if (p_valid && !p_pop && !p_fs) chk1("valid_hold", row_valid, 1'b1);
            if (row_valid) begin
                chki("row_index", int'(row_index), m_idx);
                chkw("row_data", row_data, word_of(m_idx));
            end
            if (row_valid && !p_valid) rise_cyc = cyc;
            if (frame_done) done_count++;

            pop = row_valid && row_ready;
            m_done = 1'b0;
            if (frame_start) begin
                if (m_busy && m_ovr < 255) m_ovr++;
                m_busy = 1'b1;
                m_idx  = 0;
            end else if (pop) begin
                if (m_idx == NR - 1) begin
                    m_done = 1'b1;
                    m_busy = 1'b0;
                    m_idx  = 0;
                end else begin
                    m_idx++;
                end
            end
            p_valid = row_valid;
            p_pop   = pop;
            p_fs    = frame_start;
        end
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                compare_step();
            end
            begin : stim
                int dc;
                int n;

                // Reset values
                step(); step();
                chki("rst_addr", int'(read_address), 0);
                chk1("rst_valid", row_valid, 1'b0);
                chkw("rst_data", row_data, 128'h0);
                chki("rst_index", int'(row_index), 0);
                chk1("rst_busy", busy, 1'b0);
                chk1("rst_done", frame_done, 1'b0);
                chki("rst_overrun", int'(overrun_count), 0);
                step();
                rst_n = 1'b1;

                // Basic frame: start at cycle 10
                while (cyc != 10) step();
                pulse_start();
                chk1("fetch_busy", busy, 1'b1);
                chki("fetch_addr0", int'(read_address), 0);
                wait_done("basic_done", 100);
                chki("basic_done_cycle", cyc, 58);
                step();
                chki("basic_first_valid_cycle", rise_cyc, 12);
                chk1("basic_idle_after", busy, 1'b0);
                chki("basic_done_count", done_count, 1);

                // Backpressure, then alternating ready
                row_ready = 1'b0;
                pulse_start();
                repeat (19) step();
                chki("bp_addr_hold", int'(read_address), 2);
                chk1("bp_valid", row_valid, 1'b1);
                chki("bp_head_index", int'(row_index), 0);
                dc = done_count;
                n = 0;
                while (!frame_done && n < 300) begin
                    row_ready = ~row_ready;
                    step();
                    n++;
                end
                chk1("bp_done", frame_done, 1'b1);
                row_ready = 1'b1;
                step();
                chki("bp_done_count", done_count, dc + 1);

                // frame_start coincident with the final pop
                pulse_start();
                n = 0;
                while (!(row_valid && int'(row_index) == NR - 1) && n < 100) begin
                    step();
                    n++;
                end
                chki("coin_last_row", int'(row_index), NR - 1);
                dc = done_count;
                pulse_start();
                chk1("coin_no_done", frame_done, 1'b0);
                chki("coin_overrun", int'(overrun_count), 1);
                chk1("coin_busy", busy, 1'b1);

                // Restart during FETCH at row 20
                wait_addr("ovr_reach_row20", 20, 100);
                pulse_start();
                chk1("ovr_flush_valid", row_valid, 1'b0);
                chki("ovr_count2", int'(overrun_count), 2);
                chki("ovr_addr_restart", int'(read_address), 0);
                wait_done("ovr_done", 100);
                step();
                chki("ovr_single_done", done_count, dc + 1);

                // Saturation: 300 consecutive restarts
                frame_start = 1'b1;
                repeat (301) step();
                frame_start = 1'b0;
                chki("ovr_saturate", int'(overrun_count), 255);
                wait_done("sat_done", 100);
                step();

                // Single-row build
                fs_s = 1'b1;
                step();
                fs_s = 1'b0;
                chk1("one_busy", busy_s, 1'b1);
                chki("one_addr_a", int'(addr_s), 0);
                chk1("one_valid_a", valid_s, 1'b0);
                step();
                chk1("one_valid_b", valid_s, 1'b1);
                chki("one_index", int'(index_s), 0);
                chkw("one_data", data_s, word_of(0));
                chki("one_addr_b", int'(addr_s), 0);
                chk1("one_done_early", done_s, 1'b0);
                step();
                chk1("one_done", done_s, 1'b1);
                chk1("one_idle", busy_s, 1'b0);
                chk1("one_empty", valid_s, 1'b0);
                chki("one_addr_c", int'(addr_s), 0);
                step();
                chk1("one_done_single", done_s, 1'b0);

                // Asynchronous reset mid-frame
                pulse_start();
                wait_addr("rstmid_row30", 30, 100);
                dc = done_count;
                #2 rst_n = 1'b0;
                #1;
                chki("rstmid_addr", int'(read_address), 0);
                chk1("rstmid_valid", row_valid, 1'b0);
                chkw("rstmid_data", row_data, 128'h0);
                chk1("rstmid_busy", busy, 1'b0);
                chki("rstmid_overrun", int'(overrun_count), 0);
                step(); step();
                rst_n = 1'b1;
                step();
                chk1("rstmid_idle", busy, 1'b0);
                chki("rstmid_no_done", done_count, dc);
                pulse_start();
                wait_done("rstmid_clean_done", 100);
                step();
                chki("rstmid_done_count", done_count, dc + 1);
                chki("rstmid_overrun_after", int'(overrun_count), 0);
                repeat (3) step();

                $display("%0d/%0d checks passed", passed, total);
                $finish;
            end
        join_any
    end

endmodule
